// File: rtl/count_writer.sv
// Counting-pattern writer for the FT600 245-mode TX FIFO: bursts of an incrementing
// 16-bit counter separated by idle gaps. Define COUNT_WRITER_HEADER_EN to prefix each burst with a header word.
module count_writer #(
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        tx_full,
  output logic        tx_en,
  output logic [15:0] tx_in,
  output logic        busy,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef COUNT_WRITER_HEADER_EN
    HEADER = 2'd1,
`endif
    BURST  = 2'd2,
    GAP    = 2'd3
  } state_t;

`ifdef COUNT_WRITER_HEADER_EN
  localparam state_t START = HEADER;
`else
  localparam state_t START = BURST;
`endif

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);
  // A zero-length gap still spends one cycle in GAP, so the load saturates at zero.
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] gap_q, gap_d;
  logic        busy_q;
  logic [7:0]  led_q;
  logic        write;

  // Reset also gates the strobe so the reset edge itself never writes a word.
  always_comb begin
    write = 1'b0;
    if (!rst && !tx_full) begin
`ifdef COUNT_WRITER_HEADER_EN
      write = (state_q == HEADER) || (state_q == BURST);
`else
      write = (state_q == BURST);
`endif
    end
  end

  always_comb begin
    tx_in = 16'h0000;
    case (state_q)
`ifdef COUNT_WRITER_HEADER_EN
      HEADER:  tx_in = {8'hA5, seq_q[7:0]};
`endif
      BURST:   tx_in = cnt_q;
      default: tx_in = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = START;
      end
`ifdef COUNT_WRITER_HEADER_EN
      HEADER: begin
        if (write) state_d = BURST;
      end
`endif
      BURST: begin
        if (write) begin
          cnt_d = cnt_q + 16'd1;
          if (idx_q == LAST_IDX) begin
            idx_d   = 16'd0;
            seq_d   = seq_q + 16'd1;
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == 16'd0) begin
          state_d = enable ? START : IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      seq_q   <= 16'd0;
      idx_q   <= 16'd0;
      gap_q   <= 16'd0;
      busy_q  <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      busy_q  <= (state_d != IDLE);
      led_q   <= seq_d[7:0];
    end
  end

  assign tx_en = write;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_count_writer.sv
// Directed bench for count_writer: three instances cover gapped bursts, back-to-back bursts
// and the 16-bit counter / led wrap; header expectations follow COUNT_WRITER_HEADER_EN.
module tb_count_writer;

`ifdef COUNT_WRITER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, txFull, enA, enB, enC;
  logic        txEnA, txEnB, txEnC, busyA, busyB, busyC;
  logic [15:0] txInA, txInB, txInC;
  logic [7:0]  ledA, ledB, ledC;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  count_writer #(.BURST_LEN(4), .GAP_CYCLES(2)) dutA (
    .clk(clk), .rst(rst), .enable(enA), .tx_full(txFull),
    .tx_en(txEnA), .tx_in(txInA), .busy(busyA), .led(ledA));

  count_writer #(.BURST_LEN(4), .GAP_CYCLES(0)) dutB (
    .clk(clk), .rst(rst), .enable(enB), .tx_full(txFull),
    .tx_en(txEnB), .tx_in(txInB), .busy(busyB), .led(ledB));

  count_writer #(.BURST_LEN(256), .GAP_CYCLES(0)) dutC (
    .clk(clk), .rst(rst), .enable(enC), .tx_full(1'b0),
    .tx_en(txEnC), .tx_in(txInC), .busy(busyC), .led(ledC));

  task automatic waitWriteC(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (txEnC === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; txFull = 1'b0; enA = 1'b1; enB = 1'b1; enC = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({txEnA, busyA, ledA, txInA} !== 26'd0 || {txEnB, busyB, txEnC, busyC} !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got en=%b busy=%b led=%h in=%h, want all zero",
                 i, txEnA, busyA, ledA, txInA);
      end
    end
    @(negedge clk);
    rst = 1'b0; enA = 1'b0; enB = 1'b0; enC = 1'b0;
    #1;
    @(negedge clk); #1;
    checks++;
    if (txEnA !== 1'b0 || busyA !== 1'b0 || txInA !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_idle: got en=%b busy=%b in=%h, want 0 0 0000", txEnA, busyA, txInA);
    end
  endtask

  task automatic test_basic_burst();
    logic [15:0] exp[$];
    exp = {};
    if (HDR) exp.push_back(16'hA500);
    for (int i = 0; i < 4; i++) exp.push_back(16'(i));
    @(negedge clk); enA = 1'b1; #1;
    checks++;
    if (txEnA !== 1'b0 || busyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_idle: got en=%b busy=%b, want 0 0", txEnA, busyA);
    end
    foreach (exp[i]) begin
      @(negedge clk); enA = 1'b0; #1;
      checks++;
      if (txEnA !== 1'b1 || txInA !== exp[i] || busyA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_word%0d: got en=%b in=%h busy=%b, want 1 %h 1",
                 i, txEnA, txInA, busyA, exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (txEnA !== 1'b0 || busyA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_gap%0d: got en=%b busy=%b, want 0 1", i, txEnA, busyA);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (busyA !== 1'b0 || ledA !== 8'h01 || txEnA !== 1'b0 || txInA !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL basic_done: got busy=%b led=%h en=%b in=%h, want 0 01 0 0000",
               busyA, ledA, txEnA, txInA);
    end
  endtask

  task automatic test_back_pressure();
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; enA = 1'b1; #1;
    checks++;
    if (busyA !== 1'b0 || ledA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL bp_reset: got busy=%b led=%h, want 0 00", busyA, ledA);
    end
    if (HDR) begin
      @(negedge clk); enA = 1'b0; #1;
      checks++;
      if (txEnA !== 1'b1 || txInA !== 16'hA500) begin
        errors++;
        $display("[TB] FAIL bp_header: got en=%b in=%h, want 1 A500", txEnA, txInA);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); enA = 1'b0; #1;
      checks++;
      if (txEnA !== 1'b1 || txInA !== 16'(i)) begin
        errors++;
        $display("[TB] FAIL bp_pre%0d: got en=%b in=%h, want 1 %h", i, txEnA, txInA, 16'(i));
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); txFull = 1'b1; #1;
      checks++;
      if (txEnA !== 1'b0 || busyA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d: got en=%b busy=%b, want 0 1", i, txEnA, busyA);
      end
    end
    @(negedge clk); txFull = 1'b0; #1;
    checks++;
    if (txEnA !== 1'b1 || txInA !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL bp_resume: got en=%b in=%h, want 1 0002", txEnA, txInA);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); txFull = 1'b1; #1;
      checks++;
      if (txEnA !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall_last%0d: got en=%b, want 0", i, txEnA);
      end
    end
    @(negedge clk); txFull = 1'b0; #1;
    checks++;
    if (txEnA !== 1'b1 || txInA !== 16'h0003) begin
      errors++;
      $display("[TB] FAIL bp_last: got en=%b in=%h, want 1 0003", txEnA, txInA);
    end
    @(negedge clk); #1;
    checks++;
    if (txEnA !== 1'b0 || busyA !== 1'b1 || ledA !== 8'h01) begin
      errors++;
      $display("[TB] FAIL bp_to_gap: got en=%b busy=%b led=%h, want 0 1 01", txEnA, busyA, ledA);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (busyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_idle: got busy=%b, want 0", busyA);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit idle;
    @(negedge clk); enA = 1'b1; #1;
    if (HDR) begin
      @(negedge clk); enA = 1'b0; #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); enA = 1'b0; #1;
    end
    checks++;
    if (txEnA !== 1'b1 || txInA !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL rmb_second_word: got en=%b in=%h, want 1 0005", txEnA, txInA);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (txEnA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmb_in_reset: got en=%b, want 0", txEnA);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (txEnA !== 1'b0 || busyA !== 1'b0 || ledA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rmb_after_reset: got en=%b busy=%b led=%h, want 0 0 00", txEnA, busyA, ledA);
    end
    @(negedge clk); enA = 1'b1; #1;
    @(negedge clk); enA = 1'b0; #1;
    checks++;
    if (txEnA !== 1'b1 || txInA !== (HDR ? 16'hA500 : 16'h0000)) begin
      errors++;
      $display("[TB] FAIL rmb_restart0: got en=%b in=%h, want 1 %h", txEnA, txInA,
               HDR ? 16'hA500 : 16'h0000);
    end
    @(negedge clk); #1;
    checks++;
    if (txEnA !== 1'b1 || txInA !== (HDR ? 16'h0000 : 16'h0001)) begin
      errors++;
      $display("[TB] FAIL rmb_restart1: got en=%b in=%h, want 1 %h", txEnA, txInA,
               HDR ? 16'h0000 : 16'h0001);
    end
    idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (busyA === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("[TB] FAIL rmb_timeout: got busy=%b after 20 cycles, want 0", busyA);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cnt;
    cnt = 16'd0;
    @(negedge clk); enB = 1'b1; #1;
    checks++;
    if (txEnB !== 1'b0 || busyB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got en=%b busy=%b, want 0 0", txEnB, busyB);
    end
    for (int b = 0; b < 3; b++) begin
      if (HDR) begin
        @(negedge clk); #1;
        checks++;
        if (txEnB !== 1'b1 || txInB !== {8'hA5, 8'(b)}) begin
          errors++;
          $display("[TB] FAIL b2b_header%0d: got en=%b in=%h, want 1 %h", b, txEnB, txInB, {8'hA5, 8'(b)});
        end
      end
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        if (b == 2 && w == 0) enB = 1'b0;
        #1;
        checks++;
        if (txEnB !== 1'b1 || txInB !== cnt) begin
          errors++;
          $display("[TB] FAIL b2b_data b%0d w%0d: got en=%b in=%h, want 1 %h", b, w, txEnB, txInB, cnt);
        end
        cnt++;
      end
      @(negedge clk); #1;
      checks++;
      if (txEnB !== 1'b0 || busyB !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_gap%0d: got en=%b busy=%b, want 0 1", b, txEnB, busyB);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (busyB !== 1'b0 || ledB !== 8'h03) begin
      errors++;
      $display("[TB] FAIL b2b_done: got busy=%b led=%h, want 0 03", busyB, ledB);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] cnt;
    logic [15:0] expHdr;
    bit ok, burstOk, abort, idle;
    cnt = 16'd0;
    abort = 1'b0;
    @(negedge clk); enC = 1'b1; #1;
    for (int b = 0; b < 257 && !abort; b++) begin
      burstOk = 1'b1;
      if (HDR) begin
        waitWriteC(ok);
        expHdr = {8'hA5, 8'(b)};
        if (!ok) abort = 1'b1;
        else if (txInC !== expHdr) begin
          burstOk = 1'b0;
          $display("[TB] FAIL wrap_header%0d: got %h, want %h", b, txInC, expHdr);
        end
      end
      for (int w = 0; w < 256 && !abort; w++) begin
        waitWriteC(ok);
        if (!ok) begin
          abort = 1'b1;
          break;
        end
        if (b == 255 && w == 255) begin
          checks++;
          if (txInC !== 16'hFFFF || ledC !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL wrap_top: got in=%h led=%h, want FFFF FF", txInC, ledC);
          end
        end
        if (b == 256 && w == 0) begin
          enC = 1'b0;
          checks++;
          if (txInC !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got in=%h, want 0000", txInC);
          end
        end
        if (txInC !== cnt && burstOk) begin
          burstOk = 1'b0;
          $display("[TB] FAIL wrap_data b%0d w%0d: got %h, want %h", b, w, txInC, cnt);
        end
        cnt++;
        if (b == 255 && w == 255) begin
          @(negedge clk); #1;
          checks++;
          if (ledC !== 8'h00 || txEnC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_led: got led=%h en=%b, want 00 0", ledC, txEnC);
          end
        end
      end
      checks++;
      if (!burstOk) errors++;
    end
    checks++;
    if (abort) begin
      errors++;
      $display("[TB] FAIL wrap_timeout: got no write within 4 cycles, want a write");
    end else begin
      idle = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk); #1;
        if (busyC === 1'b0) begin
          idle = 1'b1;
          break;
        end
      end
      if (!idle || ledC !== 8'h01) begin
        errors++;
        $display("[TB] FAIL wrap_end: got busy=%b led=%h, want 0 01", busyC, ledC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_back_pressure();
    test_reset_mid_burst();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_writer.md
COUNT_WRITER -- requirements
Module: count_writer

Interface
REQ-001 Parameter BURST_LEN, default 256: data words per burst, range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 16: idle cycles between bursts, range 0..65535.
REQ-003 clk  input  1: single clock; every register updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 enable  input  1: start or continue burst generation.
REQ-006 tx_full  input  1: ft600_mode245 TX FIFO full.
REQ-007 tx_en  output  1: TX FIFO write strobe; a word is written on each rising edge where tx_en=1.
REQ-008 tx_in  output  16: word presented to the TX FIFO, valid whenever tx_en=1.
REQ-009 busy  output  1: high in any state other than IDLE.
REQ-010 led  output  8: low 8 bits of the completed-burst count.

Function
REQ-011 The FSM SHALL have four states: IDLE, HEADER, BURST, GAP.
REQ-012 IDLE: if enable=1, go to HEADER (macro defined) or BURST (macro undefined); otherwise stay in IDLE.
REQ-013 tx_en SHALL be combinational: 1 when state is HEADER or BURST and tx_full=0; otherwise 0.
REQ-014 No write SHALL occur while tx_full=1. The state and counters SHALL hold with no word lost or duplicated.
REQ-015 HEADER: tx_in = {8'hA5, seq[7:0]}. On a write, go to BURST.
REQ-016 BURST: tx_in = data counter cnt[15:0]. Each write increments cnt (mod 2^16, so 16'hFFFF wraps to 16'h0000) and increments the in-burst word index.
REQ-017 BURST: the write of word BURST_LEN-1 SHALL reset the word index to 0, increment seq (mod 2^16), and go to GAP.
REQ-018 GAP: count down GAP_CYCLES cycles with tx_en=0. When the count expires, go to HEADER/BURST if enable=1, else to IDLE.
REQ-019 GAP_CYCLES=0: GAP SHALL last exactly one cycle.
REQ-020 enable=0 during HEADER or BURST SHALL NOT abort. The current burst completes; enable is sampled only in IDLE and at GAP expiry.
REQ-021 cnt SHALL be continuous across bursts and SHALL NOT reset between bursts.
REQ-022 The first word (header or data) SHALL be presentable with tx_en=1 in the cycle after enable is sampled in IDLE.
REQ-023 led = seq[7:0], registered; busy = (state != IDLE), registered or decoded from the state register.
REQ-024 Simultaneous tx_full falling and the final-word condition: the write SHALL occur and the transition to GAP SHALL take place in the same edge.

Reset
REQ-025 While rst=1 at a rising edge: state=IDLE, cnt=0, seq=0, word index=0, gap counter=0.
REQ-026 Outputs in and after the reset cycle: tx_en=0, busy=0, led=8'h00. tx_in=16'h0000 while in IDLE.
REQ-027 rst asserted mid-burst or mid-gap SHALL abandon the burst immediately. No further write SHALL occur; a partial burst is allowed.
REQ-028 rst SHALL take precedence over every other input.

Configuration
REQ-029 Macro COUNT_WRITER_HEADER_EN, when defined: each burst is preceded by one header word (REQ-015), so a burst is BURST_LEN+1 writes.
REQ-030 COUNT_WRITER_HEADER_EN undefined: the HEADER state and its logic SHALL be absent. IDLE and GAP go directly to BURST, so a burst is exactly BURST_LEN writes.

Verification
REQ-031 Reset check: rst=1 for 10 cycles with enable=1 and tx_full=0 -> tx_en=0, busy=0, led=0 throughout.
REQ-032 Basic burst (header enabled, BURST_LEN=4, GAP_CYCLES=2, tx_full=0, enable pulsed 1 cycle) -> writes A500, 0000, 0001, 0002, 0003 on consecutive cycles, then tx_en=0; busy falls after 2 gap cycles; led=01.
REQ-033 Back-pressure: tx_full=1 for 5 cycles after the 2nd data word -> no writes during stall; sequence resumes with 0002 and has no gaps or duplicates.
REQ-034 Continuous mode: enable held 1, BURST_LEN=4, GAP_CYCLES=0, 3 bursts -> headers A500, A501, A502; data 0000..000B contiguous; 1-cycle gap between bursts.
REQ-035 Wrap: preload by running 16384 bursts of 4 (header disabled) -> word after FFFF is 0000; led wraps FF->00 after burst 256.
REQ-036 Reset mid-burst: rst=1 for 1 cycle after 2 data words -> tx_en=0 the next cycle; after enable, next burst restarts at header A500 and data 0000.
